// File: rtl/matrix_result_reader.sv
// matrix_result_reader
// ---------------------------------------------------------------------------
// Captures the N*N result elements written by the matrix multiplier into a
// local buffer, then streams them out over a valid/ready interface when the
// multiplier pulses done.
//
// Parameters
//   N         matrix dimension (power of 2); buffer holds N*N elements
//   DATA_W    element width
//   COL_MAJOR 0 = stream row-major (i*N+j), 1 = stream column-major (j*N+i)
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  result writes from the multiplier (row-major addr)
//   done                one-cycle "matrix complete" pulse, starts the stream
//   out_valid/out_ready stream handshake; beat transfers when both are high
//   out_data/out_index  streamed element and its buffer address
//   out_last            high on the final beat
//   busy                high while streaming
//   overrun             sticky: write or done arrived while streaming
//   clr_overrun         synchronous clear of overrun (a new event wins)
// ---------------------------------------------------------------------------
module matrix_result_reader #(
    parameter int N         = 4,
    parameter int DATA_W    = 16,
    parameter int COL_MAJOR = 0,
    parameter int NN        = N * N,
    parameter int AW        = (NN > 1) ? $clog2(NN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AW-1:0]     out_index,
    output logic              out_last,
    output logic              busy,
    output logic              overrun,
    input  logic              clr_overrun
);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    localparam logic [AW-1:0] LAST_BEAT = AW'(NN - 1);

    state_t            state;
    logic [AW-1:0]     beat;
    logic [DATA_W-1:0] mem [NN];

    // Map a beat number to the buffer address it streams from. With N a
    // power of 2 the div/mod reduce to bit selects in synthesis.
    function automatic logic [AW-1:0] stream_index(input logic [AW-1:0] b);
        if (COL_MAJOR != 0)
            return AW'((int'(b) % N) * N + int'(b) / N);
        else
            return b;
    endfunction

    logic [AW-1:0] next_beat;
    logic [AW-1:0] next_index;
    logic          transfer;
    logic          ovr_event;

    assign next_beat  = beat + AW'(1);
    assign next_index = stream_index(next_beat);
    assign transfer   = out_valid && out_ready;
    // Any write or done that arrives while a stream is in flight is dropped.
    assign ovr_event  = (state == STREAM) && (wr_en || done);

    // Buffer is only writable while idle so the streamed matrix stays
    // coherent. No reset on the storage itself.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ovr_event)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (done) begin
                        state     <= STREAM;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        beat      <= '0;
                        out_index <= '0;
                        out_last  <= (NN == 1);
                        // Same-cycle write to address 0 must be visible on
                        // the first beat, but the RAM write lands this edge.
                        if (wr_en && wr_addr == '0)
                            out_data <= wr_data;
                        else
                            out_data <= mem[0];
                    end
                end
                STREAM: begin
                    if (transfer) begin
                        if (beat == LAST_BEAT) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            beat      <= '0;
                        end else begin
                            // Prefetch the next element so a new beat is
                            // presented every cycle under continuous ready.
                            beat      <= next_beat;
                            out_index <= next_index;
                            out_data  <= mem[next_index];
                            out_last  <= (next_beat == LAST_BEAT);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_result_reader.sv
// Testbench for matrix_result_reader: one row-major and one column-major
// instance share stimulus; a reference model fills per-instance expectation
// queues and independent monitors pop and compare on every transfer.
module tb_matrix_result_reader;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int NN = N * N;
    localparam int AW = $clog2(NN);

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, done, out_ready, clr_overrun;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic          rv, rl, rb, ro;
    logic [DW-1:0] rd;
    logic [AW-1:0] ri;
    logic          cv, cl, cb, co;
    logic [DW-1:0] cd;
    logic [AW-1:0] ci;

    always #5 clk = ~clk;

    matrix_result_reader #(.N(N), .DATA_W(DW), .COL_MAJOR(0)) dut_row (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .done(done), .out_valid(rv), .out_ready(out_ready),
        .out_data(rd), .out_index(ri), .out_last(rl), .busy(rb),
        .overrun(ro), .clr_overrun(clr_overrun)
    );

    matrix_result_reader #(.N(N), .DATA_W(DW), .COL_MAJOR(1)) dut_col (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .done(done), .out_valid(cv), .out_ready(out_ready),
        .out_data(cd), .out_index(ci), .out_last(cl), .busy(cb),
        .overrun(co), .clr_overrun(clr_overrun)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] index;
        logic          last;
    } beat_t;

    beat_t         q_row[$];
    beat_t         q_col[$];
    logic [DW-1:0] model_mem [NN];
    bit            m_stream = 0;
    int            m_left   = 0;
    bit            m_ovr    = 0;
    int            tests    = 0;
    int            fails    = 0;
    int            mode     = 0;
    int            pat_cnt  = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: a matrix in memory, a "streaming" flag and a count of
    // beats still owed. On an accepted done it lists the whole expected
    // stream for both orders.
    always @(posedge clk) begin
        if (!reset) begin
            if (m_stream && (wr_en || done)) m_ovr = 1;
            else if (clr_overrun)            m_ovr = 0;
            if (m_stream) begin
                if (out_ready) begin
                    m_left--;
                    if (m_left == 0) m_stream = 0;
                end
            end else begin
                if (wr_en) model_mem[wr_addr] = wr_data;
                if (done) begin
                    int k;
                    m_stream = 1;
                    m_left   = NN;
                    for (int r = 0; r < NN; r++)
                        q_row.push_back('{model_mem[r], AW'(r), (r == NN - 1)});
                    k = 0;
                    for (int j = 0; j < N; j++)
                        for (int i = 0; i < N; i++) begin
                            q_col.push_back('{model_mem[i*N+j], AW'(i*N+j), (k == NN - 1)});
                            k++;
                        end
                end
            end
        end
    end

    // Monitors
    beat_t prev_r, prev_c;
    bit    hold_r = 0, hold_c = 0;

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            hold_r = 0;
        end else begin
            chk("row_valid", rv, m_stream);
            chk("row_busy", rb, m_stream);
            chk("row_overrun", ro, m_ovr);
            if (rv && hold_r) chk("row_hold", {rd, ri, rl}, prev_r);
            if (rv && out_ready) begin
                tests++;
                if (q_row.size() == 0) begin
                    fails++;
                    $display("FAIL row_unexpected_beat: got data %0h index %0d, expected no beat", rd, ri);
                end else begin
                    e = q_row.pop_front();
                    if ({rd, ri, rl} !== e) begin
                        fails++;
                        $display("FAIL row_beat: got data %0h idx %0d last %0b expected data %0h idx %0d last %0b",
                                 rd, ri, rl, e.data, e.index, e.last);
                    end
                end
            end
            hold_r = rv && !out_ready;
            prev_r = {rd, ri, rl};
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            hold_c = 0;
        end else begin
            chk("col_valid", cv, m_stream);
            chk("col_busy", cb, m_stream);
            chk("col_overrun", co, m_ovr);
            if (cv && hold_c) chk("col_hold", {cd, ci, cl}, prev_c);
            if (cv && out_ready) begin
                tests++;
                if (q_col.size() == 0) begin
                    fails++;
                    $display("FAIL col_unexpected_beat: got data %0h index %0d, expected no beat", cd, ci);
                end else begin
                    e = q_col.pop_front();
                    if ({cd, ci, cl} !== e) begin
                        fails++;
                        $display("FAIL col_beat: got data %0h idx %0d last %0b expected data %0h idx %0d last %0b",
                                 cd, ci, cl, e.data, e.index, e.last);
                    end
                end
            end
            hold_c = cv && !out_ready;
            prev_c = {cd, ci, cl};
        end
    end

    // Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
        pat_cnt++;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((pat_cnt % 4) == 0) || ((pat_cnt % 4) == 3);
            default: out_ready = ($urandom % 3) != 0;
        endcase
    endtask

    task automatic idle_inputs();
        wr_en = 0; done = 0; clr_overrun = 0;
    endtask

    task automatic load(input bit seq);
        for (int k = 0; k < NN; k++) begin
            wr_en   = 1;
            wr_addr = AW'(k);
            wr_data = seq ? DW'(k + 1) : DW'($urandom);
            tick();
        end
        idle_inputs();
    endtask

    task automatic pulse_done();
        done = 1;
        tick();
        done = 0;
    endtask

    // Wait for the stream to finish and the scoreboards to drain; optionally
    // inject stray writes, dones and overrun clears while streaming.
    task automatic wait_idle(input bit spur);
        int cyc = 0;
        while (m_stream || q_row.size() != 0 || q_col.size() != 0) begin
            if (spur && m_stream) begin
                wr_en       = ($urandom % 8) == 0;
                done        = ($urandom % 10) == 0;
                clr_overrun = ($urandom % 6) == 0;
                wr_addr     = AW'($urandom);
                wr_data     = DW'($urandom);
            end else begin
                idle_inputs();
            end
            tick();
            cyc++;
            if (cyc > 500) begin
                tests++;
                fails++;
                $display("FAIL stream_timeout: stream still pending after %0d cycles, required completion", cyc);
                break;
            end
        end
        idle_inputs();
    endtask

    task automatic apply_reset_mid();
        reset = 1;
        q_row.delete();
        q_col.delete();
        m_stream = 0; m_left = 0; m_ovr = 0;
        #1;
        chk("rst_row_valid", rv, 0);
        chk("rst_row_busy", rb, 0);
        chk("rst_col_valid", cv, 0);
        chk("rst_col_busy", cb, 0);
        chk("rst_row_data", rd, 0);
        chk("rst_row_index", ri, 0);
    endtask

    initial begin
        int cyc;
        reset = 1; out_ready = 0; wr_addr = '0; wr_data = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", rv, 0);
        chk("reset_out_data", rd, 0);
        chk("reset_out_index", ri, 0);
        chk("reset_out_last", rl, 0);
        chk("reset_busy", rb, 0);
        chk("reset_overrun", ro, 0);
        chk("reset_col_valid", cv, 0);
        reset = 0;
        tick();

        // Sequential load, full-rate drain in both orders
        mode = 0;
        load(1);
        pulse_done();
        wait_idle(0);

        // Backpressure 1,0,0,1
        load(0);
        mode = 1;
        pat_cnt = 0;
        pulse_done();
        wait_idle(0);

        // Write to address 0 together with done: bypass onto first beat
        mode = 2;
        wr_en = 1; wr_addr = '0; wr_data = 16'hBEEF; done = 1;
        tick();
        idle_inputs();
        wait_idle(0);

        // Overrun from stray write and done mid-stream, then clear
        mode = 0;
        pulse_done();
        tick();
        wr_en = 1; wr_addr = AW'($urandom); wr_data = DW'($urandom);
        tick();
        wr_en = 0; done = 1;
        tick();
        done = 0;
        chk("overrun_set", ro, 1);
        wait_idle(0);
        clr_overrun = 1;
        tick();
        clr_overrun = 0;
        chk("overrun_cleared", ro, 0);

        // Set beats clear in the same cycle
        pulse_done();
        wr_en = 1; clr_overrun = 1;
        tick();
        idle_inputs();
        chk("overrun_set_wins", ro, 1);
        wait_idle(0);
        clr_overrun = 1;
        tick();
        clr_overrun = 0;

        // Reset after five beats, then restart from index 0
        load(0);
        mode = 0;
        pulse_done();
        cyc = 0;
        while (m_left != NN - 5 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("reached_beat5", m_left, NN - 5);
        apply_reset_mid();
        tick();
        reset = 0;
        tick();
        pulse_done();
        wait_idle(0);

        // Back-to-back: done in the cycle right after the last transfer
        pulse_done();
        cyc = 0;
        while (m_stream && cyc < 100) begin
            tick();
            cyc++;
        end
        pulse_done();
        wait_idle(0);

        // Randomised rounds
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, NN + 4);
            for (int w = 0; w < nw; w++) begin
                wr_en   = 1;
                wr_addr = AW'($urandom);
                wr_data = DW'($urandom);
                done    = (w == nw - 1) && ($urandom % 2 == 1);
                tick();
            end
            idle_inputs();
            mode = $urandom_range(0, 2);
            if (!m_stream) pulse_done();
            wait_idle(1);
            if ($urandom % 2 == 1) begin
                clr_overrun = 1;
                tick();
                clr_overrun = 0;
            end
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_result_reader.md
Name: matrix_result_reader

Overview:
Read-side companion to the 4x4 matrix multiplier. It captures the 16 result elements the multiplier writes, one per cycle, into a local buffer. On the multiplier's done pulse it streams the buffer out over a valid/ready interface. Sits between the multiplier core and any downstream consumer such as a UART packer or a checker.

Parameters:
N, 4, matrix dimension; the buffer holds N*N elements; must be a power of 2.
DATA_W, 16, result element width; matches the multiplier's 16-bit accumulator.
COL_MAJOR, 0, streaming order: 0 = row-major (index i*N+j), 1 = column-major (index j*N+i).

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
wr_en  input  1  result write strobe from the multiplier.
wr_addr  input  log2(N*N)  result address, row-major (i*N+j).
wr_data  input  DATA_W  result element.
done  input  1  one-cycle pulse from the multiplier; matrix complete.
out_valid  output  1  out_data/out_index/out_last are valid.
out_ready  input  1  consumer accepts the beat.
out_data  output  DATA_W  streamed element.
out_index  output  log2(N*N)  buffer address of the current element.
out_last  output  1  high on the final beat (beat N*N-1).
busy  output  1  high while in STREAM.
overrun  output  1  sticky error flag.
clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, overrun=0, state=IDLE, beat counter=0. Buffer contents are not reset.
- States: IDLE and STREAM.
- IDLE:
  - wr_en writes wr_data to buf[wr_addr] at the clock edge.
  - done=1 moves the block to STREAM at that same edge.
  - At that edge, out_valid goes 1, out_index=0, out_data=buf[0], out_last=0 (out_last=1 only when N*N=1).
  - Latency from done to first valid beat is one edge.
- Write and done in the same cycle, in IDLE:
  - The write is committed.
  - If wr_addr equals the first stream address (0), out_data takes wr_data (bypass).
- Transfer rule: a beat transfers on an edge where out_valid && out_ready.
- Output stability: while out_valid && !out_ready, out_data, out_index and out_last hold stable.
- Beat counter: after each transfer the counter b increments.
  - out_index = b when COL_MAJOR=0.
  - out_index = (b mod N)*N + (b div N) when COL_MAJOR=1.
  - out_data = buf[out_index], presented registered on the next edge. Zero-bubble streaming is required: one beat per cycle when out_ready is held high.
- Last beat: out_last=1 exactly when b=N*N-1. When that beat transfers, the state returns to IDLE, out_valid=0, busy=0 and the counter clears, all at that edge.
- busy mirrors state==STREAM and is registered with the state.
- Writes during STREAM: wr_en is ignored (the buffer is unchanged) and overrun is set.
- Done during STREAM: done is ignored (no restart) and overrun is set.
- Overrun: sticky; cleared only by reset or by clr_overrun. When clr_overrun and a new overrun event occur in the same cycle, set wins.
- Reset mid-stream: all outputs return to their reset values immediately (asynchronous). The next done restarts the stream from index 0.
- Back-to-back: done in the cycle immediately after the last-beat transfer is accepted normally, since the block is back in IDLE.

Test Plan:
- Load and stream, row-major: write buf[k]=k+1 for k=0..15, pulse done, out_ready=1 -> 16 consecutive beats with data 1..16 and index 0..15; out_last only on data=16; busy low on the following cycle.
- Column-major (COL_MAJOR=1), same load -> data sequence 1,5,9,13,2,6,10,14,3,7,11,15,4,8,12,16; out_last on 16.
- Backpressure: out_ready toggled 1,0,0,1 repeating -> no beat lost or duplicated; outputs hold during ready=0; full 1..16 sequence received.
- Simultaneous write and done: write buf[0]=0xBEEF in the same cycle as done -> first beat out_data=0xBEEF, index 0.
- Overrun: wr_en and a second done asserted mid-stream -> overrun=1, stream contents unchanged, no restart; clr_overrun -> overrun=0 on the next edge.
- Reset mid-stream: assert reset after beat 5 -> out_valid=0, busy=0 immediately; done after release -> stream restarts at index 0 with the buffer contents unchanged.
